// File: rtl/two_by_one_mux_if.sv
// two_by_one_mux_if: data, select and valid signals shared by two_by_one_mux and its driver
interface two_by_one_mux_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] I0;
  logic [WIDTH-1:0] I1;
  logic             S0;
  logic             in_valid;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] Y_q;
  logic             sel_q;
  logic             out_valid;
  logic [CNT_W-1:0] sw_count;
  modport master (output I0, I1, S0, in_valid, input Y, Y_q, sel_q, out_valid, sw_count);
  modport slave  (input I0, I1, S0, in_valid, output Y, Y_q, sel_q, out_valid, sw_count);
endinterface

// File: rtl/two_by_one_mux.sv
// two_by_one_mux: 2:1 mux with registered valid-qualified copy; TWO_BY_ONE_MUX_SWITCH_CNT_EN adds a saturating select-switch counter
module two_by_one_mux #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  two_by_one_mux_if.slave  bus
);
  logic [WIDTH-1:0] y_q;
  logic             sel_q;
  logic             out_valid;
  // a ternary keeps agreeing bits defined when S0 is X in simulation
  assign bus.Y         = bus.S0 ? bus.I1 : bus.I0;
  assign bus.Y_q       = y_q;
  assign bus.sel_q     = sel_q;
  assign bus.out_valid = out_valid;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      y_q       <= '0;
      sel_q     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        y_q   <= bus.Y;
        sel_q <= bus.S0;
      end
    end
`ifdef TWO_BY_ONE_MUX_SWITCH_CNT_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (bus.in_valid && bus.S0 != sel_q && !(&cnt)) cnt <= cnt + CNT_W'(1);
  assign bus.sw_count = cnt;
`else
  assign bus.sw_count = '0;
`endif
endmodule

// File: tb/tb_two_by_one_mux.sv
// tb_two_by_one_mux: directed vectors with a scoreboard queue checked by a monitor on the falling edge
module tb_two_by_one_mux;
  typedef struct packed {
    logic [7:0] y;
    logic       s;
    logic [1:0] c;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  int   total = 0;
  int   passed = 0;
  exp_t q[$];
  exp_t last = '0;
  logic       msel = 1'b0;
  logic [1:0] mcnt = 2'd0;
  two_by_one_mux_if #(.WIDTH(8), .CNT_W(2)) bus();
  two_by_one_mux #(.WIDTH(8), .CNT_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 if (run) clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask
  // monitor: pop on every out_valid, otherwise the registered outputs must hold
  always @(negedge clk) if (run) begin
    if (bus.out_valid) begin
      if (q.size() == 0) chk("unexpected_out_valid", 32'(bus.out_valid), 0);
      else begin
        last = q.pop_front();
        chk("y_q", 32'(bus.Y_q), 32'(last.y));
        chk("sel_q", 32'(bus.sel_q), 32'(last.s));
        chk("sw_count", 32'(bus.sw_count), 32'(last.c));
      end
    end else begin
      chk("hold_y_q", 32'(bus.Y_q), 32'(last.y));
      chk("hold_sel_q", 32'(bus.sel_q), 32'(last.s));
      chk("hold_sw_count", 32'(bus.sw_count), 32'(last.c));
    end
  end
  task automatic sample(input logic [7:0] a, input logic [7:0] b, input logic s, input logic v, input logic [7:0] ey);
    @(posedge clk);
    #1;
    bus.I0 = a;
    bus.I1 = b;
    bus.S0 = s;
    bus.in_valid = v;
    if (v) begin
`ifdef TWO_BY_ONE_MUX_SWITCH_CNT_EN
      if (s != msel && mcnt != 2'd3) mcnt = mcnt + 2'd1;
`endif
      msel = s;
      q.push_back({ey, s, mcnt});
    end
    #1 chk("comb_y", 32'(bus.Y), 32'(ey));
  endtask
  task automatic async_reset(input logic [7:0] ey, input logic want_ov);
    @(posedge clk);
    #1;
    if (want_ov) chk("ov_before_rst", 32'(bus.out_valid), 1);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_y_q", 32'(bus.Y_q), 0);
    chk("rst_sel_q", 32'(bus.sel_q), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_sw_count", 32'(bus.sw_count), 0);
    chk("rst_comb_y", 32'(bus.Y), 32'(ey));
    q.delete();
    last = '0;
    msel = 1'b0;
    mcnt = 2'd0;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask
  initial begin
    logic [7:0] tt_y;
    bus.I0 = '0;
    bus.I1 = '0;
    bus.S0 = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("init_y_q", 32'(bus.Y_q), 0);
    chk("init_sel_q", 32'(bus.sel_q), 0);
    chk("init_out_valid", 32'(bus.out_valid), 0);
    chk("init_sw_count", 32'(bus.sw_count), 0);
    // truth table with the clock stopped and reset held: (I0,I1,S0) counting 000..111
    tt_y = 8'b1101_1000;
    for (int i = 0; i < 8; i++) begin
      bus.I0 = {8{i[2]}};
      bus.I1 = {8{i[1]}};
      bus.S0 = i[0];
      #100 chk("truth_table", 32'(bus.Y), 32'({8{tt_y[i]}}));
    end
    bus.I0 = '0;
    bus.I1 = '0;
    bus.S0 = 1'b0;
    run = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    sample(8'h01, 8'h00, 1'b0, 1'b1, 8'h01);
    sample(8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    sample(8'hFF, 8'h0F, 1'b1, 1'b1, 8'h0F);
    async_reset(8'h0F, 1'b1);
    sample(8'hAA, 8'h55, 1'b1, 1'b1, 8'h55);
    sample(8'hAA, 8'h55, 1'b1, 1'b1, 8'h55);
    sample(8'hAA, 8'h55, 1'b0, 1'b1, 8'hAA);
    sample(8'hAA, 8'h55, 1'b1, 1'b1, 8'h55);
    sample(8'hAA, 8'h55, 1'b1, 1'b0, 8'h55);
    @(negedge clk);
`ifdef TWO_BY_ONE_MUX_SWITCH_CNT_EN
    chk("cnt_seq_1101", 32'(bus.sw_count), 3);
`else
    chk("cnt_seq_1101", 32'(bus.sw_count), 0);
`endif
    async_reset(8'h55, 1'b0);
    sample(8'hA5, 8'h3C, 1'b1, 1'b1, 8'h3C);
    sample(8'hA5, 8'h3C, 1'b0, 1'b1, 8'hA5);
    sample(8'hA5, 8'h3C, 1'b1, 1'b1, 8'h3C);
    sample(8'hA5, 8'h3C, 1'b0, 1'b1, 8'hA5);
    sample(8'hA5, 8'h3C, 1'b1, 1'b1, 8'h3C);
    sample(8'hA5, 8'h3C, 1'b0, 1'b1, 8'hA5);
    sample(8'hA5, 8'h3C, 1'b0, 1'b0, 8'hA5);
    @(negedge clk);
`ifdef TWO_BY_ONE_MUX_SWITCH_CNT_EN
    chk("cnt_saturate", 32'(bus.sw_count), 3);
`else
    chk("cnt_saturate", 32'(bus.sw_count), 0);
`endif
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
